// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: two requester channels and one response channel.
// The master side drives requests and takes responses; the slave side is the arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  resp_valid, resp_id, result, zero, negative,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output resp_valid, resp_id, result, zero, negative,
        input  resp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// One operation in flight: grant in IDLE, compute in EXEC, hold the response in RESP.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_next;

    logic             last_grant;
    logic             grant_any;
    logic             grant_id;

    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [2:0]       op_p0;
    logic             id_p0;

    logic [WIDTH-1:0] result_p1;
    logic             resp_id_p1;

    // Shared ALU; illegal opcodes produce zero.
    function automatic logic [WIDTH-1:0] alu_eval(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [2:0]       op);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH-1:0]        res;
        sa = a;
        sb = b;
        case (op)
            3'b000:  res = a + b;
            3'b001:  res = a - b;
            3'b010:  res = a & b;
            3'b011:  res = a | b;
            3'b100:  res = a ^ b;
            3'b101:  res = {{(WIDTH-1){1'b0}}, (sa < sb)};
            default: res = '0;
        endcase
        return res;
    endfunction

    // Round-robin grant decision; only offered in IDLE and never while reset is high.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE && !reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end else if (bus.req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Last-grant memory; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset)          last_grant <= 1'b1;
        else if (grant_any) last_grant <= grant_id;
    end

    // Stage p0: capture the granted operands so later bus changes cannot leak in.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            a_p0  <= grant_id ? bus.req1_a  : bus.req0_a;
            b_p0  <= grant_id ? bus.req1_b  : bus.req0_b;
            op_p0 <= grant_id ? bus.req1_op : bus.req0_op;
            id_p0 <= grant_id;
        end
    end

    // Stage p1: register the ALU result in EXEC; it holds through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_p1  <= '0;
            resp_id_p1 <= 1'b0;
        end else if (state == EXEC) begin
            result_p1  <= alu_eval(a_p0, b_p0, op_p0);
            resp_id_p1 <= id_p0;
        end
    end

    assign bus.req0_ready = grant_any && !grant_id;
    assign bus.req1_ready = grant_any &&  grant_id;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_id    = resp_id_p1;
    assign bus.result     = result_p1;
    assign bus.zero       = (result_p1 == '0);
    assign bus.negative   = result_p1[WIDTH-1];
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  in  WIDTH each  requester 0 operands.
REQ-007 req0_op  in  3  requester 0 opcode.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op: same as REQ-004..007 for requester 1.
REQ-009 resp_valid  out  1  result held on response bus.
REQ-010 resp_ready  in  1  consumer takes result this cycle.
REQ-011 resp_id  out  1  requester that owns the result.
REQ-012 result  out  WIDTH  registered ALU result.
REQ-013 zero  out  1  high iff result is all zeroes.
REQ-014 negative  out  1  result[WIDTH-1].

Function
REQ-015 Block SHALL time-share one ALU between two requesters; at most one operation in flight.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP.
REQ-017 IDLE: if any reqN_valid, grant one, pulse its reqN_ready for exactly that cycle, latch a/b/op/id, go to EXEC; else stay.
REQ-018 Arbitration SHALL be round-robin: on simultaneous valid, grant the requester not granted last; last-grant register SHALL reset to 1 (requester 0 wins first tie).
REQ-019 A single valid requester SHALL be granted regardless of last-grant.
REQ-020 EXEC: compute on latched operands, register result/zero/negative/resp_id, go to RESP; lasts exactly one cycle.
REQ-021 Opcodes: 000 a+b, 001 a-b, 010 a&b, 011 a|b, 100 a^b, 101 signed a<b (result 1 or 0); 110/111 SHALL give result 0.
REQ-022 Add/sub SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-023 zero SHALL derive from the registered result (all WIDTH bits zero), including for illegal opcodes (zero=1).
REQ-024 RESP: resp_valid=1; result, zero, negative, resp_id SHALL stay stable until resp_ready sampled high.
REQ-025 RESP with resp_ready=1: go to IDLE next cycle; resp_valid low that cycle; no new grant in the same cycle.
REQ-026 reqN_ready SHALL be 0 in EXEC and RESP; requests held during those states wait.
REQ-027 Minimum request-to-response latency: grant at cycle T, resp_valid at T+2; back-to-back grants at best every 3 cycles.
REQ-028 Operand changes after grant SHALL NOT affect the in-flight result.

Reset
REQ-029 reset high at a clock edge SHALL force IDLE, resp_valid=0, req0_ready=req1_ready=0, result=0, zero=1, negative=0, resp_id=0, last-grant=1, from any state.
REQ-030 In-flight operation at reset SHALL be discarded; no response is produced for it.

Verification
REQ-031 Req0 only, op=001, a=5, b=5, resp_ready=1 -> req0_ready pulse T, resp_valid T+2, result=0, zero=1, resp_id=0.
REQ-032 Both valid every cycle from reset, op=000, a=1,b=2 / a=7,b=8 -> grants alternate 0,1,0,1; results 3,15 alternating.
REQ-033 Req1 op=000 a=0xFFFFFFFF b=1, resp_ready=0 for 5 cycles -> result=0, zero=1 held stable; no grant to pending req0 until ready.
REQ-034 Op=101 a=0x80000000 b=1 -> result=1, zero=0, negative=0; op=111 -> result=0, zero=1.
REQ-035 reset asserted during EXEC and during RESP -> next cycle IDLE, resp_valid=0, all outputs at REQ-029 values; following tie grants requester 0.
REQ-036 Operands changed the cycle after grant (a=3,b=4 -> a=9,b=9, op=000) -> result=7.
